// File: rtl/flash_loader_pkg.sv
// flash_loader_pkg: shared states, SPI/ramio constants and byte-order helper for flash_loader.
package flash_loader_pkg;
    typedef enum logic [2:0] {Send, Receive, Write, WaitWrite, Done} state_t;

    localparam logic [7:0] FlashCmdRead   = 8'h03;
    localparam logic [1:0] RamioWriteWord = 2'b11;
    localparam int         SpiBitCycles   = 2;

    // Flash bytes arrive first-byte-in-MSB; RAM words are little-endian.
    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/flash_loader_if.sv
// flash_loader_if: SPI flash pins and ramio write port seen by the boot loader.
interface flash_loader_if;
    logic        flash_clk;
    logic        flash_mosi;
    logic        flash_miso;
    logic        flash_cs_n;
    logic        ramio_enable;
    logic [1:0]  ramio_write_type;
    logic [2:0]  ramio_read_type;
    logic [31:0] ramio_address;
    logic [31:0] ramio_data_in;
    logic        ramio_busy;

    modport master (
        output flash_clk, flash_mosi, flash_cs_n,
        output ramio_enable, ramio_write_type, ramio_read_type, ramio_address, ramio_data_in,
        input  flash_miso, ramio_busy
    );

    modport slave (
        input  flash_clk, flash_mosi, flash_cs_n,
        input  ramio_enable, ramio_write_type, ramio_read_type, ramio_address, ramio_data_in,
        output flash_miso, ramio_busy
    );
endinterface

// File: rtl/flash_loader_spi_shift_master.sv
// spi_shift_master: mode-0 SPI shifter; sends TxWord once, then keeps clocking in 32-bit words.
// stall parks the clock in its low phase; a high phase in progress always completes.
module spi_shift_master
    import flash_loader_pkg::*;
#(
    parameter logic [31:0] TxWord = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        word_done,
    output logic [31:0] rx
);
    localparam int            PW   = $clog2(SpiBitCycles);
    localparam logic [PW-1:0] Half = PW'(SpiBitCycles / 2);
    localparam logic [PW-1:0] Last = PW'(SpiBitCycles - 1);

    logic [PW-1:0] ph;
    logic [4:0]    cnt;
    logic [31:0]   tx;

    assign sclk      = ph >= Half;
    assign mosi      = tx[31];
    assign word_done = ph == Last && cnt == 5'd31;

    always_ff @(posedge clk) begin
        if (rst) begin
            ph  <= '0;
            cnt <= '0;
            tx  <= TxWord;
            rx  <= '0;
        end else if (ph == Last) begin
            ph  <= '0;
            cnt <= cnt + 5'd1;
            tx  <= {tx[30:0], 1'b0};
        end else if (sclk || !stall) begin
            ph <= ph + 1'b1;
            if (ph == Half - 1'b1) rx <= {rx[30:0], miso};
        end
    end
endmodule

// File: rtl/flash_loader.sv
// flash_loader: boot-time copier from SPI flash into ramio as little-endian words.
// FLASH_LOADER_CHECKSUM_EN adds a running 32-bit sum of written words on checksum.
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter int          TransferByteCount = 2048,
    parameter logic [23:0] FlashStartAddress = 24'h0,
    parameter logic [31:0] RamStartAddress   = 32'h0
) (
    input  logic           clk,
    input  logic           rst,
    flash_loader_if.master bus,
    output logic           busy,
    output logic           done,
    output logic [31:0]    checksum
);
    state_t      state, state_n;
    logic        skip, skip_n, cs_n, en, stall, last, word_done, sclk, mosi;
    logic [31:0] rx, addr, data;

    spi_shift_master #(.TxWord({FlashCmdRead, FlashStartAddress})) spi (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .miso      (bus.flash_miso),
        .sclk      (sclk),
        .mosi      (mosi),
        .word_done (word_done),
        .rx        (rx)
    );

    // Any ramio backpressure freezes the flash stream as well as the write path.
    assign stall = cs_n || bus.ramio_busy || (state != Send && state != Receive);
    assign last  = addr == RamStartAddress + 32'(TransferByteCount) - 32'd4;

    assign bus.flash_clk        = sclk;
    assign bus.flash_mosi       = mosi && !cs_n;
    assign bus.flash_cs_n       = cs_n;
    assign bus.ramio_enable     = en;
    assign bus.ramio_write_type = en ? RamioWriteWord : 2'b00;
    assign bus.ramio_read_type  = 3'b000;
    assign bus.ramio_address    = addr;
    assign bus.ramio_data_in    = data;
    assign busy                 = !cs_n;
    assign done                 = state == Done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= Send;
            skip  <= 1'b0;
            cs_n  <= 1'b1;
            addr  <= RamStartAddress;
            data  <= '0;
        end else begin
            state <= state_n;
            skip  <= skip_n;
            cs_n  <= state_n == Done;
            if (state == Receive && word_done) data <= bswap(rx);
            if (state == WaitWrite && state_n != WaitWrite) addr <= addr + 32'd4;
        end
    end

    always_comb begin
        state_n = state;
        skip_n  = skip;
        en      = 1'b0;
        unique case (state)
            Send:      state_n = (TransferByteCount == 0) ? Done : (word_done ? Receive : Send);
            Receive:   state_n = word_done ? Write : Receive;
            Write: if (!bus.ramio_busy) begin
                en      = 1'b1;
                skip_n  = 1'b1;
                state_n = WaitWrite;
            end
            // The cycle after a request is ignored: ramio raises busy only one cycle later.
            WaitWrite: begin
                skip_n = 1'b0;
                if (!skip && !bus.ramio_busy) state_n = last ? Done : Receive;
            end
            Done: ;
        endcase
    end

`ifdef FLASH_LOADER_CHECKSUM_EN
    logic [31:0] sum;

    always_ff @(posedge clk) sum <= rst ? '0 : (en ? sum + data : sum);

    assign checksum = sum;
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: randomized self-checking bench; flash byte-stream model, ramio slave and word-queue reference.
`timescale 1ns/1ps
module tb_flash_loader;
    localparam int Bytes = 2048;
    localparam int Words = Bytes / 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy_o, done_o, zbusy, zdone;
    logic [31:0] csum_o, zcsum;

    flash_loader_if bus();
    flash_loader_if zbus();

    flash_loader #(.TransferByteCount(Bytes), .FlashStartAddress(24'h0), .RamStartAddress(32'h0)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy_o), .done(done_o), .checksum(csum_o)
    );

    flash_loader #(.TransferByteCount(0), .FlashStartAddress(24'h0), .RamStartAddress(32'h0)) zdut (
        .clk(clk), .rst(rst), .bus(zbus), .busy(zbusy), .done(zdone), .checksum(zcsum)
    );

    assign zbus.flash_miso = 1'b0;
    assign zbus.ramio_busy = 1'b0;

    always #5 clk = ~clk;

    logic [7:0]  img [Bytes];
    logic [31:0] ram [Words];
    logic [31:0] fcmd, msum;
    int          cyc = 0, widx = 0, last_en = 0, done_due = -1, rises = 0, hold = 0, blen = 0;
    int          passed = 0, total = 0;
    bit          rnd_mode = 0, pin_timing = 1, cmd_chk = 0, exp_done = 0;
    logic        pmosi = 1'b0, pbusy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] exp_word(input int k);
        return {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]};
    endfunction

    function automatic logic img_bit(input int j);
        int idx;
        idx = (int'(fcmd[23:0]) + j / 8) % Bytes;
        return img[idx][7 - j % 8];
    endfunction

    // Flash: command bits clocked in on rising flash_clk, data driven after each falling edge.
    initial forever begin
        @(posedge bus.flash_cs_n);
        rises = 0;
    end

    initial forever begin
        @(posedge bus.flash_clk);
        if (rises < 32) fcmd = {fcmd[30:0], bus.flash_mosi};
        rises++;
    end

    initial forever begin
        @(negedge bus.flash_clk);
        if (rises >= 32 && !bus.flash_cs_n) bus.flash_miso = img_bit(rises - 32);
    end

    // ramio slave busy driver: post-write busy bursts, forced holds, random idle blips.
    initial forever begin
        @(posedge clk);
        cyc = rst ? 0 : cyc + 1;
        #1;
        if (hold > 0) begin
            bus.ramio_busy = 1'b1;
            hold--;
        end else if (blen > 0) begin
            bus.ramio_busy = 1'b1;
            blen--;
        end else begin
            bus.ramio_busy = rnd_mode && $urandom_range(15) == 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (cyc == 0) begin
            chk("rst_cs_n", bus.flash_cs_n, 1);
            chk("rst_sclk", bus.flash_clk, 0);
            chk("rst_mosi", bus.flash_mosi, 0);
            chk("rst_en", bus.ramio_enable, 0);
            chk("rst_wtype", bus.ramio_write_type, 0);
            chk("rst_addr", bus.ramio_address, 0);
            chk("rst_data", bus.ramio_data_in, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_done", done_o, 0);
            chk("rst_csum", csum_o, 0);
            chk("rst_zdone", zdone, 0);
            chk("rst_zcs_n", zbus.flash_cs_n, 1);
            widx     = 0;
            msum     = 0;
            done_due = -1;
            cmd_chk  = 0;
        end else begin
            exp_done = done_due >= 0 && cyc >= done_due;
            chk("done", done_o, exp_done);
            chk("busy", busy_o, !exp_done);
            chk("cs_n", bus.flash_cs_n, exp_done);
            chk("rtype", bus.ramio_read_type, 0);
            chk("wtype", bus.ramio_write_type, bus.ramio_enable ? 32'd3 : 32'd0);
`ifdef FLASH_LOADER_CHECKSUM_EN
            chk("checksum", csum_o, msum);
`else
            chk("checksum", csum_o, 0);
`endif
            if (pbusy && bus.ramio_busy) chk("stall_sclk", bus.flash_clk, 0);
            if (bus.flash_mosi !== pmosi) chk("mosi_phase", bus.flash_clk, 0);
            if (rises >= 32 && !cmd_chk) begin
                chk("mosi_cmd", fcmd, 32'h03000000);
                cmd_chk = 1;
            end
            if (bus.ramio_enable) begin
                chk("en_while_busy", bus.ramio_busy, 0);
                chk("extra_write", widx < Words, 1);
                if (widx < Words) begin
                    chk("addr", bus.ramio_address, 32'(4 * widx));
                    chk("data", bus.ramio_data_in, exp_word(widx));
                    if (widx == 0) chk("first_word_lit", bus.ramio_data_in, 32'h00010113);
                    if (widx == 0 && pin_timing) chk("first_write_cycle", cyc, 129);
                    ram[bus.ramio_address[12:2]] = bus.ramio_data_in;
                    msum += exp_word(widx);
                    widx++;
                    last_en = cyc;
                    blen = rnd_mode ? $urandom_range(0, 4) : 0;
                end
            end
            if (widx == Words && done_due < 0 && cyc >= last_en + 2 && !bus.ramio_busy) done_due = cyc + 1;
            chk("z_done", zdone, 1);
            chk("z_cs_n", zbus.flash_cs_n, 1);
            chk("z_en", zbus.ramio_enable, 0);
            chk("z_busy", zbusy, 0);
        end
        pmosi = bus.flash_mosi;
        pbusy = bus.ramio_busy;
    end

    initial begin
        bus.flash_miso = 1'b0;
        bus.ramio_busy = 1'b0;
        img[0] = 8'h13;
        img[1] = 8'h01;
        img[2] = 8'h01;
        img[3] = 8'h00;
        for (int i = 4; i < Bytes; i++) img[i] = 8'($urandom);
        for (int i = 0; i < Words; i++) ram[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20000 && rises < 96; i++) @(negedge clk);
        chk("word1_received", rises >= 96, 1);
        hold = 50;
        for (int i = 0; i < 3000 && widx < 2; i++) @(negedge clk);
        chk("write_after_hold", widx, 2);
        rnd_mode   = 1;
        pin_timing = 0;
        for (int i = 0; i < 3000 && widx < 3; i++) @(negedge clk);
        chk("reached_word3", widx, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 80000 && !done_o; i++) @(negedge clk);
        chk("done_reached", done_o, 1);
        chk("write_count", widx, 512);
        repeat (10) @(negedge clk);
        for (int k = 0; k < Words; k++) chk("ram_image", ram[k], exp_word(k));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
